// File: rtl/projection_histogram.sv
// Builds X/Y projection histograms of a binary pixel stream, tracks per-axis peaks,
// and streams the bins out over a valid/ready read port.
module projection_histogram #(
    parameter int unsigned IMWIDTH       = 240,
    parameter int unsigned IMHEIGHT      = 180,
    parameter int unsigned BIN_W         = 8,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned CLEAR_ON_READ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              read,
    input  logic              pix_valid,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [ADDR_W-1:0] y_addr,
    input  logic              pix_data,
    output logic [BIN_W-1:0]  x_out,
    output logic [BIN_W-1:0]  y_out,
    output logic [ADDR_W-1:0] out_index,
    output logic              x_valid,
    output logic              y_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [BIN_W-1:0]  x_peak_val,
    output logic [BIN_W-1:0]  y_peak_val,
    output logic [ADDR_W-1:0] x_peak_idx,
    output logic [ADDR_W-1:0] y_peak_idx,
    output logic              idle,
    output logic              done
);

    localparam int unsigned NBINS = (IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [BIN_W-1:0] BIN_MAX = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_CLEAR   = 2'd2;
    localparam logic [1:0] S_READ    = 2'd3;

    logic              rst_meta;
    logic              rst_n;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_xv;
    logic              rd_yv;
    logic              x_hit;
    logic              y_hit;
    logic [BIN_W-1:0]  x_new;
    logic [BIN_W-1:0]  y_new;
    logic              beat_acc;
    logic              last_acc;
    logic              load_beat;

    logic [BIN_W-1:0]  xbin [IMWIDTH];
    logic [BIN_W-1:0]  ybin [IMHEIGHT];

    // Assert asynchronously, release two edges after reset deasserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    assign rd_idx    = cnt[ADDR_W-1:0];
    assign rd_xv     = cnt < CNT_W'(IMWIDTH);
    assign rd_yv     = cnt < CNT_W'(IMHEIGHT);
    assign beat_acc  = out_valid && out_ready;
    assign last_acc  = beat_acc && out_last;
    assign load_beat = (state_q == S_READ) && (!out_valid || (beat_acc && !out_last));

    // Saturating increment candidates; out-of-range addresses leave their axis alone.
    always_comb begin
        x_hit = 1'b0;
        y_hit = 1'b0;
        x_new = '0;
        y_new = '0;
        if (state_q == S_COMPUTE && pix_valid && pix_data) begin
            x_hit = {1'b0, x_addr} < CNT_W'(IMWIDTH);
            y_hit = {1'b0, y_addr} < CNT_W'(IMHEIGHT);
        end
        if (x_hit) x_new = (xbin[x_addr] == BIN_MAX) ? BIN_MAX : xbin[x_addr] + BIN_W'(1);
        if (y_hit) y_new = (ybin[y_addr] == BIN_MAX) ? BIN_MAX : ybin[y_addr] + BIN_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start)      state_d = S_COMPUTE;
                else if (clear) state_d = S_CLEAR;
                else if (read)  state_d = S_READ;
            end
            S_COMPUTE: if (stop) state_d = S_IDLE;
            S_CLEAR:   if (cnt == CNT_W'(NBINS)) state_d = S_IDLE;
            S_READ:    if (last_acc) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            x_valid    <= 1'b0;
            y_valid    <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            out_index  <= '0;
            x_peak_val <= '0;
            y_peak_val <= '0;
            x_peak_idx <= '0;
            y_peak_idx <= '0;
            done       <= 1'b0;
            idle       <= 1'b1;
        end else begin
            done <= 1'b0;
            idle <= (state_d == S_IDLE);
            if (state_q == S_IDLE) cnt <= '0;
            if (x_hit && x_new > x_peak_val) begin
                x_peak_val <= x_new;
                x_peak_idx <= x_addr;
            end
            if (y_hit && y_new > y_peak_val) begin
                y_peak_val <= y_new;
                y_peak_idx <= y_addr;
            end
            // One index per cycle, then a final cycle that carries done.
            if (state_q == S_CLEAR) begin
                x_peak_val <= '0;
                y_peak_val <= '0;
                x_peak_idx <= '0;
                y_peak_idx <= '0;
                if (cnt == CNT_W'(NBINS)) done <= 1'b1;
                else                      cnt  <= cnt + CNT_W'(1);
            end
            if (load_beat) begin
                out_valid <= 1'b1;
                out_index <= rd_idx;
                x_valid   <= rd_xv;
                y_valid   <= rd_yv;
                x_out     <= rd_xv ? xbin[rd_idx] : '0;
                y_out     <= rd_yv ? ybin[rd_idx] : '0;
                out_last  <= (cnt == CNT_W'(NBINS - 1));
                cnt       <= cnt + CNT_W'(1);
            end else if (last_acc) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                x_valid   <= 1'b0;
                y_valid   <= 1'b0;
                done      <= 1'b1;
                if (CLEAR_ON_READ != 0) begin
                    x_peak_val <= '0;
                    y_peak_val <= '0;
                    x_peak_idx <= '0;
                    y_peak_idx <= '0;
                end
            end
        end
    end

    // Bin storage is deliberately not reset; a CLEAR initialises it.
    always_ff @(posedge clk) begin
        if (x_hit) xbin[x_addr] <= x_new;
        if (y_hit) ybin[y_addr] <= y_new;
        if (state_q == S_CLEAR) begin
            if (rd_xv) xbin[rd_idx] <= '0;
            if (rd_yv) ybin[rd_idx] <= '0;
        end
        if (CLEAR_ON_READ != 0 && beat_acc) begin
            if (x_valid) xbin[out_index] <= '0;
            if (y_valid) ybin[out_index] <= '0;
        end
    end

endmodule

// File: tb/tb_projection_histogram.sv
// Scoreboard bench: a default instance and a swapped-size, clear-on-read instance share stimulus.
module tb_projection_histogram;

    typedef struct packed {
        logic [7:0] idx;
        logic       xv;
        logic       yv;
        logic [7:0] xo;
        logic [7:0] yo;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, clear, read;
    logic       pix_valid, pix_data;
    logic [7:0] x_addr, y_addr;
    logic       out_ready;
    bit         rnd_ready = 1'b0;

    logic [7:0] xo_a, yo_a, idx_a, xpv_a, ypv_a, xpi_a, ypi_a;
    logic       xv_a, yv_a, ov_a, last_a, idle_a, done_a;
    logic [7:0] xo_b, yo_b, idx_b, xpv_b, ypv_b, xpi_b, ypi_b;
    logic       xv_b, yv_b, ov_b, last_b, idle_b, done_b;

    int total = 0;
    int bad   = 0;
    int beats_a, beats_b;
    beat_t qa[$];
    beat_t qb[$];
    logic [7:0] ex_a[240], ey_a[240], ex_b[240], ey_b[240];
    bit    held_a = 1'b0, held_b = 1'b0;
    beat_t hold_a, hold_b, ga, gb;

    always #5 clk = ~clk;

    projection_histogram dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .read(read),
        .pix_valid(pix_valid), .x_addr(x_addr), .y_addr(y_addr), .pix_data(pix_data),
        .x_out(xo_a), .y_out(yo_a), .out_index(idx_a), .x_valid(xv_a), .y_valid(yv_a),
        .out_valid(ov_a), .out_ready(out_ready), .out_last(last_a),
        .x_peak_val(xpv_a), .y_peak_val(ypv_a), .x_peak_idx(xpi_a), .y_peak_idx(ypi_a),
        .idle(idle_a), .done(done_a)
    );

    projection_histogram #(.IMWIDTH(180), .IMHEIGHT(240), .CLEAR_ON_READ(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .read(read),
        .pix_valid(pix_valid), .x_addr(x_addr), .y_addr(y_addr), .pix_data(pix_data),
        .x_out(xo_b), .y_out(yo_b), .out_index(idx_b), .x_valid(xv_b), .y_valid(yv_b),
        .out_valid(ov_b), .out_ready(out_ready), .out_last(last_b),
        .x_peak_val(xpv_b), .y_peak_val(ypv_b), .x_peak_idx(xpi_b), .y_peak_idx(ypi_b),
        .idle(idle_b), .done(done_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_beat(input int d, input beat_t got);
        beat_t e;
        if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected dut%0d got=%0h exp=none", d, got);
        end else begin
            e = (d == 0) ? qa.pop_front() : qb.pop_front();
            chk($sformatf("beat_dut%0d_idx%0d", d, e.idx), 32'(got), 32'(e));
        end
    endtask

    // Monitor: pops on every accepted beat and checks that stalled beats hold.
    always @(negedge clk) begin
        ga = {idx_a, xv_a, yv_a, xo_a, yo_a, last_a};
        gb = {idx_b, xv_b, yv_b, xo_b, yo_b, last_b};
        if (!reset) begin
            held_a = 1'b0;
            held_b = 1'b0;
        end else begin
            if (held_a) chk("hold_a", 32'({ov_a, ga}), 32'({1'b1, hold_a}));
            if (held_b) chk("hold_b", 32'({ov_b, gb}), 32'({1'b1, hold_b}));
            if (ov_a && out_ready) begin check_beat(0, ga); beats_a++; end
            if (ov_b && out_ready) begin check_beat(1, gb); beats_b++; end
            held_a = ov_a && !out_ready;
            held_b = ov_b && !out_ready;
            hold_a = ga;
            hold_b = gb;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_exp();
        for (int i = 0; i < 240; i++) begin
            ex_a[i] = 8'd0; ey_a[i] = 8'd0; ex_b[i] = 8'd0; ey_b[i] = 8'd0;
        end
    endtask

    task automatic push_read();
        for (int i = 0; i < 240; i++) begin
            beat_t e;
            e.idx  = 8'(i);
            e.last = (i == 239);
            e.xv   = 1'b1;
            e.yv   = (i < 180);
            e.xo   = ex_a[i];
            e.yo   = e.yv ? ey_a[i] : 8'd0;
            qa.push_back(e);
            e.xv   = (i < 180);
            e.yv   = 1'b1;
            e.xo   = e.xv ? ex_b[i] : 8'd0;
            e.yo   = ey_b[i];
            qb.push_back(e);
        end
        for (int i = 0; i < 240; i++) begin
            ex_b[i] = 8'd0; ey_b[i] = 8'd0;
        end
    endtask

    task automatic chk_peaks(input string tag, input logic [31:0] exp);
        chk({tag, "_a"}, {xpv_a, xpi_a, ypv_a, ypi_a}, exp);
        chk({tag, "_b"}, {xpv_b, xpi_b, ypv_b, ypi_b}, exp);
    endtask

    task automatic do_clear();
        int n = 0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        while (n < 400) begin
            cyc();
            n++;
            if (done_a) break;
        end
        chk("clear_cycles", n, 241);
        chk("clear_done_b", done_b, 1);
        chk_peaks("clear_peaks", 0);
        cyc();
        chk("clear_done_pulse", {done_a, done_b, idle_a, idle_b}, 4'b0011);
        zero_exp();
    endtask

    task automatic do_read();
        int n = 0;
        beats_a = 0;
        beats_b = 0;
        push_read();
        read = 1'b1;
        cyc();
        read = 1'b0;
        chk("rd_first_lat0", {ov_a, ov_b, idle_a}, 3'b000);
        cyc();
        chk("rd_first_lat1", {ov_a, ov_b, idx_a, idx_b}, {2'b11, 16'h0000});
        while (n < 5000 && !done_a) begin
            cyc();
            n++;
        end
        chk("rd_done", {done_a, done_b, idle_a, idle_b}, 4'b1111);
        chk("rd_beats", {beats_a[15:0], beats_b[15:0]}, {16'd240, 16'd240});
        chk("rd_queues_empty", qa.size() + qb.size(), 0);
    endtask

    task automatic pixel(input logic [7:0] x, input logic [7:0] y, input logic d, input logic s);
        pix_valid = 1'b1; pix_data = d; x_addr = x; y_addr = y; stop = s;
        cyc();
        pix_valid = 1'b0; pix_data = 1'b0; stop = 1'b0;
    endtask

    task automatic begin_compute();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("compute_entry", {idle_a, idle_b}, 2'b00);
    endtask

    initial begin
        int dn;
        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; read = 1'b0;
        pix_valid = 1'b0; pix_data = 1'b0; x_addr = 8'd0; y_addr = 8'd0;
        zero_exp();
        repeat (3) cyc();
        chk("rst_ctrl_a", {idle_a, ov_a, last_a, xv_a, yv_a, done_a}, 6'b100000);
        chk("rst_ctrl_b", {idle_b, ov_b, last_b, xv_b, yv_b, done_b}, 6'b100000);
        chk("rst_data", {xo_a, yo_a, idx_a, xo_b}, 0);
        chk_peaks("rst_peaks", 0);
        reset = 1'b1;
        repeat (4) cyc();

        do_clear();
        do_read();

        // Three hits at (5,7), a dropped pix_data=0 beat, then (9,7) on the stop edge.
        begin_compute();
        repeat (3) pixel(8'd5, 8'd7, 1'b1, 1'b0);
        pixel(8'd5, 8'd7, 1'b0, 1'b0);
        pixel(8'd9, 8'd7, 1'b1, 1'b1);
        chk("stop_idle", {idle_a, idle_b}, 2'b11);
        chk_peaks("peaks_57", {8'd3, 8'd5, 8'd4, 8'd7});
        ex_a[5] = 8'd3; ex_a[9] = 8'd1; ey_a[7] = 8'd4;
        ex_b[5] = 8'd3; ex_b[9] = 8'd1; ey_b[7] = 8'd4;
        do_read();
        chk("peaks_after_read_a", {xpv_a, xpi_a, ypv_a, ypi_a}, {8'd3, 8'd5, 8'd4, 8'd7});
        chk("peaks_after_read_b", {xpv_b, xpi_b, ypv_b, ypi_b}, 0);

        rnd_ready = 1'b1;
        do_read();
        rnd_ready = 1'b0;

        do_clear();
        begin_compute();
        repeat (300) pixel(8'd0, 8'd0, 1'b1, 1'b0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_peaks("peaks_sat", {8'd255, 8'd0, 8'd255, 8'd0});
        ex_a[0] = 8'd255; ey_a[0] = 8'd255; ex_b[0] = 8'd255; ey_b[0] = 8'd255;
        do_read();

        do_clear();
        begin_compute();
        pixel(8'd250, 8'd3, 1'b1, 1'b1);
        chk_peaks("peaks_oob", {8'd0, 8'd0, 8'd1, 8'd3});
        ey_a[3] = 8'd1; ey_b[3] = 8'd1;
        rnd_ready = 1'b1;
        do_read();
        rnd_ready = 1'b0;

        // Reset in the middle of a read: immediate idle, no done afterwards.
        push_read();
        read = 1'b1;
        cyc();
        read = 1'b0;
        repeat (30) cyc();
        chk("midread_active", {ov_a, idle_a}, 2'b10);
        reset = 1'b0;
        #1;
        chk("midread_rst_idle", {idle_a, idle_b, ov_a, ov_b, done_a, done_b}, 6'b110000);
        chk("midread_rst_peaks_a", {ypv_a, ypi_a}, 0);
        qa.delete();
        qb.delete();
        dn = 0;
        repeat (3) begin cyc(); if (done_a || done_b) dn++; end
        reset = 1'b1;
        repeat (8) begin cyc(); if (done_a || done_b) dn++; end
        chk("midread_no_done", dn, 0);
        chk("midread_after", {idle_a, idle_b, ov_a, ov_b}, 4'b1100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/projection_histogram.md
PROJECTION_HISTOGRAM -- requirements
Module: projection_histogram

Interface
REQ-001 The module SHALL have parameter IMWIDTH, default 240, giving the number of X bins.
REQ-002 The module SHALL have parameter IMHEIGHT, default 180, giving the number of Y bins.
REQ-003 The module SHALL have parameter BIN_W, default 8, giving the width of each bin count.
REQ-004 The module SHALL have parameter ADDR_W, default 8, giving the address and index width; it SHALL be at least clog2(max(IMWIDTH,IMHEIGHT)).
REQ-005 The module SHALL have parameter CLEAR_ON_READ, default 0; when 1, each bin is zeroed once its read beat is accepted.
REQ-006 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = reset).
REQ-008 The module SHALL have ports start, stop, clear and read, each an input of 1 bit, acting as single-cycle command pulses.
REQ-009 The module SHALL have ports pix_valid (input, 1), x_addr (input, ADDR_W), y_addr (input, ADDR_W) and pix_data (input, 1), forming the pixel stream.
REQ-010 The module SHALL have ports x_out and y_out (output, BIN_W each), carrying the bin counts for a read beat.
REQ-011 The module SHALL have ports out_index (output, ADDR_W), x_valid (output, 1) and y_valid (output, 1), qualifying the read beat per axis.
REQ-012 The module SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1), forming the read-stream handshake.
REQ-013 The module SHALL have ports x_peak_val and y_peak_val (output, BIN_W each) and x_peak_idx and y_peak_idx (output, ADDR_W each), giving the running maximum bin per axis.
REQ-014 The module SHALL have ports idle (output, 1), high in IDLE, and done (output, 1), a one-cycle pulse when CLEAR or READ completes.

Function
REQ-015 The module SHALL implement states IDLE, COMPUTE, CLEAR and READ.
REQ-016 In IDLE, start SHALL move to COMPUTE, else clear SHALL move to CLEAR, else read SHALL move to READ; priority is start > clear > read.
REQ-017 Commands SHALL be ignored outside IDLE, except stop in COMPUTE, which returns to IDLE on the next edge.
REQ-018 In COMPUTE, a cycle with pix_valid=1 and pix_data=1 SHALL increment xbin[x_addr] and ybin[y_addr] by one, with the written value visible to the next cycle's increment.
REQ-019 Increments SHALL saturate at 2^BIN_W-1 with no wrap-around.
REQ-020 An x_addr >= IMWIDTH SHALL leave the X axis unchanged, and a y_addr >= IMHEIGHT SHALL leave the Y axis unchanged; the other axis still updates.
REQ-021 On each increment, if the new bin value is strictly greater than the axis peak value, the peak value and peak index SHALL take the new value and that address; on a tie the earlier peak is kept.
REQ-022 A pixel accepted on the same edge that stop is sampled SHALL still be counted.
REQ-023 CLEAR SHALL zero one index per cycle on both axes, for N = max(IMWIDTH,IMHEIGHT) cycles, and SHALL zero both peak values and indices.
REQ-024 CLEAR SHALL then pulse done for one cycle while returning to IDLE, for N+1 cycles total from entry.
REQ-025 READ SHALL stream indices 0..N-1, presenting one beat per index.
REQ-026 x_valid SHALL be high only when out_index < IMWIDTH and y_valid only when out_index < IMHEIGHT; an axis whose valid is low SHALL output 0.
REQ-027 The first beat's out_valid SHALL rise one cycle after entering READ.
REQ-028 A beat SHALL be held stable, including all data and index outputs, while out_valid=1 and out_ready=0.
REQ-029 The next beat SHALL be loaded on the edge where out_valid and out_ready are both high.
REQ-030 out_last SHALL be high on beat N-1; its acceptance SHALL clear out_valid, pulse done and return the block to IDLE.
REQ-031 When CLEAR_ON_READ=1, an accepted bin SHALL be zeroed and the peaks SHALL be zeroed at done.
REQ-032 Peak outputs SHALL be continuously driven and SHALL change only in COMPUTE or as set by REQ-023 and REQ-031.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, with out_valid, out_last, x_valid, y_valid and done at 0, x_out, y_out and out_index at 0, peaks at 0 and idle at 1.
REQ-034 Bin arrays SHALL NOT be reset; a CLEAR is required before first use.
REQ-035 reset asserted mid-READ or mid-CLEAR SHALL abort the operation without a done pulse.
REQ-036 Release of reset SHALL be synchronised so that the first active edge occurs cleanly after deassertion.

Verification
REQ-037 The bench SHALL cover: reset, then clear -> done exactly N+1=241 cycles after entry, then read returns all zeros, 240 beats, out_last on beat 239.
REQ-038 The bench SHALL cover: start, then 3 pixels at (5,7) and 1 at (9,7), then stop -> read gives x[5]=3, x[9]=1, y[7]=4, x_peak=(3,5) and y_peak=(4,7).
REQ-039 The bench SHALL cover: 300 pixels at (0,0) with BIN_W=8 -> x[0]=y[0]=255 and no wrap.
REQ-040 The bench SHALL cover: x_addr=250 and y_addr=3 with a pixel -> no X change and y[3] increments; x_valid is low for indices 180-239 only when IMHEIGHT > IMWIDTH is configured, checked with swapped parameters.
REQ-041 The bench SHALL cover: out_ready randomly toggled during read -> every index 0..N-1 seen exactly once, in order, with stable held data.
REQ-042 The bench SHALL cover: CLEAR_ON_READ=1 -> a second read after the first returns all zeros, and reset mid-READ -> idle=1 immediately with no done pulse.
